// File: rtl/acc_fixed_mc.sv
// Per-channel signed frame accumulator; tlast closes a channel frame and pushes {sum, tid, ovf} into a FWFT result FIFO.
// Latency: result is visible the cycle after the tlast beat (FIFO empty); one beat/cycle including same-channel back-to-back.
// Backpressure: s_axis_a_tready = !fifo_full (registered count, no in->out path); `ACC_SAT_EN selects clamping instead of wrap.
module acc_fixed_mc #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 40,
    parameter int CH        = 4,
    parameter int CH_W      = (CH > 1) ? $clog2(CH) : 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic [CH_W-1:0]   s_axis_a_tid,
    input  logic              s_axis_a_tlast,
    output logic              m_axis_result_tvalid,
    input  logic              m_axis_result_tready,
    output logic [ACC_W-1:0]  m_axis_result_tdata,
    output logic [CH_W-1:0]   m_axis_result_tid,
    output logic              m_axis_result_tuser,
    output logic [15:0]       count_dropped
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam logic [CH_W:0]  CH_LIM  = (CH_W + 1)'(CH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(OUT_DEPTH);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CH_W-1:0]  id;
        logic             ovf;
    } res_t;

    logic             beat_acc;
    logic             in_range;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    logic [ACC_W-1:0] acc_q [CH];
    logic [ACC_W-1:0] acc_d [CH];
    logic [CH-1:0]    ovf_q;
    logic [CH-1:0]    ovf_d;

    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] sum_final;
    logic             add_ovf;
    logic             frame_ovf;

    res_t             fifo_q [OUT_DEPTH];
    res_t             push_ent;
    res_t             head_ent;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    logic [15:0]      dropped_q;
    logic [15:0]      dropped_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign full            = (count_q == DEPTH_C);
    assign empty           = (count_q == '0);
    assign s_axis_a_tready = !areset && !full;
    assign beat_acc        = s_axis_a_tvalid && s_axis_a_tready;
    assign in_range        = ({1'b0, s_axis_a_tid} < CH_LIM);
    assign push            = beat_acc && in_range && s_axis_a_tlast;
    assign pop             = m_axis_result_tvalid && m_axis_result_tready;

    // ------------------------------------------------------------------
    // Add datapath: single-cycle read-modify-write on the addressed channel
    // ------------------------------------------------------------------
    assign acc_cur   = acc_q[s_axis_a_tid];
    assign addend    = ACC_W'($signed(s_axis_a_tdata));
    assign sum_raw   = acc_cur + addend;
    assign add_ovf   = (acc_cur[ACC_W-1] == addend[ACC_W-1]) &&
                       (sum_raw[ACC_W-1] != acc_cur[ACC_W-1]);
    assign frame_ovf = ovf_q[s_axis_a_tid] | add_ovf;

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both operands share a sign, so the current sign picks the rail.
    always_comb begin
        sum_final = sum_raw;
        if (add_ovf) begin
            sum_final = acc_cur[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum_final = sum_raw;
`endif

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (beat_acc && in_range) begin
            if (s_axis_a_tlast) begin
                acc_d[s_axis_a_tid] = '0;
                ovf_d[s_axis_a_tid] = 1'b0;
            end else begin
                acc_d[s_axis_a_tid] = sum_final;
                ovf_d[s_axis_a_tid] = frame_ovf;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Dropped-beat counter (tid beyond CH), saturating
    // ------------------------------------------------------------------
    always_comb begin
        dropped_d = dropped_q;
        if (beat_acc && !in_range && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign count_dropped = dropped_q;

    // ------------------------------------------------------------------
    // Result FIFO, first-word fall-through
    // ------------------------------------------------------------------
    always_comb begin
        push_ent.sum = sum_final;
        push_ent.id  = s_axis_a_tid;
        push_ent.ovf = frame_ovf;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Entries are cleared on reset so the idle head reads as all-zero.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_ent;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_ent             = fifo_q[rd_ptr_q];
    assign m_axis_result_tvalid = !empty;
    assign m_axis_result_tdata  = head_ent.sum;
    assign m_axis_result_tid    = head_ent.id;
    assign m_axis_result_tuser  = head_ent.ovf;

endmodule

// File: tb/tb_acc_fixed_mc.sv
// Directed bench: instance "a" (CH=4, ACC_W=40) for framing/backpressure/reset,
// instance "b" (CH=3, ACC_W=34) for overflow and out-of-range channel ids.
module tb_acc_fixed_mc;

    logic        aclk = 1'b0;
    logic        areset;
    always #5 aclk = ~aclk;

    logic        a_vld, a_rdy, a_last, r_vld, r_rdy, r_user;
    logic [31:0] a_dat;
    logic [1:0]  a_id, r_id;
    logic [39:0] r_dat;
    logic [15:0] a_drop;

    logic        b_vld, b_rdy, b_last, q_vld, q_rdy, q_user;
    logic [31:0] b_dat;
    logic [1:0]  b_id, q_id;
    logic [33:0] q_dat;
    logic [15:0] b_drop;

    int tests = 0;
    int fails = 0;

    acc_fixed_mc #(.DATA_W(32), .ACC_W(40), .CH(4), .OUT_DEPTH(4)) u_a (
        .aclk(aclk), .areset(areset),
        .s_axis_a_tvalid(a_vld), .s_axis_a_tready(a_rdy), .s_axis_a_tdata(a_dat),
        .s_axis_a_tid(a_id), .s_axis_a_tlast(a_last),
        .m_axis_result_tvalid(r_vld), .m_axis_result_tready(r_rdy),
        .m_axis_result_tdata(r_dat), .m_axis_result_tid(r_id),
        .m_axis_result_tuser(r_user), .count_dropped(a_drop)
    );

    acc_fixed_mc #(.DATA_W(32), .ACC_W(34), .CH(3), .OUT_DEPTH(4)) u_b (
        .aclk(aclk), .areset(areset),
        .s_axis_a_tvalid(b_vld), .s_axis_a_tready(b_rdy), .s_axis_a_tdata(b_dat),
        .s_axis_a_tid(b_id), .s_axis_a_tlast(b_last),
        .m_axis_result_tvalid(q_vld), .m_axis_result_tready(q_rdy),
        .m_axis_result_tdata(q_dat), .m_axis_result_tid(q_id),
        .m_axis_result_tuser(q_user), .count_dropped(b_drop)
    );

    task automatic send_a(input logic [31:0] d, input logic [1:0] id, input logic last);
        int n = 0;
        a_vld = 1'b1; a_dat = d; a_id = id; a_last = last;
        while (!a_rdy && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        tests++;
        if (a_rdy !== 1'b1) begin
            fails++; $display("FAIL send_a_timeout ready=%b want 1", a_rdy);
        end
        @(posedge aclk); #1;
        a_vld = 1'b0; a_last = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic [1:0] id, input logic last);
        int n = 0;
        b_vld = 1'b1; b_dat = d; b_id = id; b_last = last;
        while (!b_rdy && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        tests++;
        if (b_rdy !== 1'b1) begin
            fails++; $display("FAIL send_b_timeout ready=%b want 1", b_rdy);
        end
        @(posedge aclk); #1;
        b_vld = 1'b0; b_last = 1'b0;
    endtask

    task automatic pop_a();
        r_rdy = 1'b1; @(posedge aclk); #1; r_rdy = 1'b0;
    endtask

    task automatic pop_b();
        q_rdy = 1'b1; @(posedge aclk); #1; q_rdy = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        a_vld = 0; a_dat = 0; a_id = 0; a_last = 0; r_rdy = 0;
        b_vld = 0; b_dat = 0; b_id = 0; b_last = 0; q_rdy = 0;
        #1 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL rst_tready got %b want 0", a_rdy); end
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b want 0", r_vld); end
        tests++; if (r_dat !== 40'd0 || r_id !== 2'd0 || r_user !== 1'b0) begin
            fails++; $display("FAIL rst_fields got %h/%h/%b want 0/0/0", r_dat, r_id, r_user);
        end
        tests++; if (a_drop !== 16'd0) begin fails++; $display("FAIL rst_dropped got %0d want 0", a_drop); end
        areset = 1'b0;
        #1;
        tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL rst_release_tready got %b want 1", a_rdy); end
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        send_a(32'd100, 2'd0, 1'b0);
        send_a(32'd100, 2'd0, 1'b0);
        send_a(32'd100, 2'd0, 1'b0);
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", r_vld); end
        send_a(32'd100, 2'd0, 1'b1);
        tests++; if (r_vld !== 1'b1) begin fails++; $display("FAIL basic_latency tvalid got %b want 1", r_vld); end
        tests++; if (r_dat !== 40'd400) begin fails++; $display("FAIL basic_tdata got %0d want 400", r_dat); end
        tests++; if (r_id !== 2'd0 || r_user !== 1'b0) begin
            fails++; $display("FAIL basic_tid_tuser got %0d/%b want 0/0", r_id, r_user);
        end
        pop_a();
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL basic_drained tvalid got %b want 0", r_vld); end
    endtask

    task automatic test_interleave();
        send_a(32'd5, 2'd0, 1'b0);
        send_a(32'hFFFF_FFF9, 2'd1, 1'b0);
        send_a(32'd5, 2'd0, 1'b1);
        send_a(32'hFFFF_FFF9, 2'd1, 1'b1);
        tests++; if (r_dat !== 40'd10 || r_id !== 2'd0) begin
            fails++; $display("FAIL ilv_first got %h/%0d want 000000000a/0", r_dat, r_id);
        end
        pop_a();
        tests++; if (r_vld !== 1'b1 || r_dat !== 40'hFF_FFFF_FFF2 || r_id !== 2'd1) begin
            fails++; $display("FAIL ilv_second got v%b %h/%0d want v1 fffffffff2/1", r_vld, r_dat, r_id);
        end
        pop_a();
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL ilv_drained got %b want 0", r_vld); end
    endtask

    task automatic test_back_to_back();
        send_a(32'd10, 2'd2, 1'b0);
        send_a(32'hFFFF_FFFD, 2'd2, 1'b0);
        send_a(32'd1000, 2'd2, 1'b1);
        send_a(32'd7, 2'd2, 1'b1);
        tests++; if (r_dat !== 40'd1007 || r_id !== 2'd2) begin
            fails++; $display("FAIL b2b_sum got %0d/%0d want 1007/2", r_dat, r_id);
        end
        pop_a();
        tests++; if (r_dat !== 40'd7 || r_vld !== 1'b1) begin
            fails++; $display("FAIL b2b_restart got %0d v%b want 7 v1", r_dat, r_vld);
        end
        pop_a();
    endtask

    task automatic test_backpressure();
        r_rdy = 1'b0;
        send_a(32'd11, 2'd0, 1'b1);
        send_a(32'd22, 2'd1, 1'b1);
        send_a(32'd33, 2'd2, 1'b1);
        send_a(32'd44, 2'd3, 1'b1);
        tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", a_rdy); end
        repeat (2) @(posedge aclk);
        #1;
        tests++; if (r_vld !== 1'b1 || r_dat !== 40'd11 || r_id !== 2'd0) begin
            fails++; $display("FAIL bp_hold got v%b %0d/%0d want v1 11/0", r_vld, r_dat, r_id);
        end
        a_vld = 1'b1; a_dat = 32'd55; a_id = 2'd1; a_last = 1'b1;
        r_rdy = 1'b1;
        @(posedge aclk); #1;
        tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got %b want 1", a_rdy); end
        tests++; if (r_dat !== 40'd22 || r_id !== 2'd1) begin
            fails++; $display("FAIL bp_drain2 got %0d/%0d want 22/1", r_dat, r_id);
        end
        @(posedge aclk); #1;
        a_vld = 1'b0; a_last = 1'b0;
        tests++; if (r_dat !== 40'd33 || r_id !== 2'd2) begin
            fails++; $display("FAIL bp_drain3 got %0d/%0d want 33/2", r_dat, r_id);
        end
        @(posedge aclk); #1;
        tests++; if (r_dat !== 40'd44 || r_id !== 2'd3) begin
            fails++; $display("FAIL bp_drain4 got %0d/%0d want 44/3", r_dat, r_id);
        end
        @(posedge aclk); #1;
        tests++; if (r_vld !== 1'b1 || r_dat !== 40'd55 || r_id !== 2'd1 || r_user !== 1'b0) begin
            fails++; $display("FAIL bp_fifth got v%b %0d/%0d/%b want v1 55/1/0", r_vld, r_dat, r_id, r_user);
        end
        @(posedge aclk); #1;
        r_rdy = 1'b0;
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", r_vld); end
    endtask

    task automatic test_overflow();
        logic [33:0] exp_sum;
`ifdef ACC_SAT_EN
        exp_sum = 34'h1_FFFF_FFFF;
`else
        exp_sum = 34'h2_7FFF_FFFB;
`endif
        for (int i = 0; i < 5; i++) begin
            send_b(32'h7FFF_FFFF, 2'd2, (i == 4));
        end
        tests++; if (q_vld !== 1'b1 || q_dat !== exp_sum) begin
            fails++; $display("FAIL ovf_tdata got v%b %h want v1 %h", q_vld, q_dat, exp_sum);
        end
        tests++; if (q_user !== 1'b1 || q_id !== 2'd2) begin
            fails++; $display("FAIL ovf_tuser got %b/%0d want 1/2", q_user, q_id);
        end
        pop_b();
        send_b(32'd1, 2'd2, 1'b1);
        tests++; if (q_dat !== 34'd1 || q_user !== 1'b0) begin
            fails++; $display("FAIL ovf_next_frame got %h/%b want 1/0", q_dat, q_user);
        end
        pop_b();
    endtask

    task automatic test_invalid_id();
        send_b(32'd3, 2'd0, 1'b0);
        send_b(32'd4, 2'd1, 1'b0);
        send_b(32'd5, 2'd2, 1'b0);
        send_b(32'd77, 2'd3, 1'b1);
        tests++; if (q_vld !== 1'b0) begin fails++; $display("FAIL inv_no_result got %b want 0", q_vld); end
        tests++; if (b_drop !== 16'd1) begin fails++; $display("FAIL inv_count got %0d want 1", b_drop); end
        send_b(32'd3, 2'd0, 1'b1);
        send_b(32'd4, 2'd1, 1'b1);
        send_b(32'd5, 2'd2, 1'b1);
        tests++; if (q_dat !== 34'd6 || q_id !== 2'd0) begin
            fails++; $display("FAIL inv_ch0 got %0d/%0d want 6/0", q_dat, q_id);
        end
        pop_b();
        tests++; if (q_dat !== 34'd8 || q_id !== 2'd1) begin
            fails++; $display("FAIL inv_ch1 got %0d/%0d want 8/1", q_dat, q_id);
        end
        pop_b();
        tests++; if (q_dat !== 34'd10 || q_id !== 2'd2) begin
            fails++; $display("FAIL inv_ch2 got %0d/%0d want 10/2", q_dat, q_id);
        end
        pop_b();
    endtask

    task automatic test_reset_midframe();
        send_a(32'd123, 2'd1, 1'b1);
        tests++; if (r_vld !== 1'b1) begin fails++; $display("FAIL rmf_pending got %b want 1", r_vld); end
        send_a(32'd50, 2'd3, 1'b0);
        send_a(32'd50, 2'd3, 1'b0);
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL rmf_discard got %b want 0", r_vld); end
        tests++; if (b_drop !== 16'd0) begin fails++; $display("FAIL rmf_dropped_clr got %0d want 0", b_drop); end
        @(posedge aclk); #1;
        send_a(32'd9, 2'd3, 1'b1);
        tests++; if (r_vld !== 1'b1 || r_dat !== 40'd9 || r_id !== 2'd3 || r_user !== 1'b0) begin
            fails++; $display("FAIL rmf_result got v%b %0d/%0d/%b want v1 9/3/0", r_vld, r_dat, r_id, r_user);
        end
        pop_a();
        tests++; if (r_vld !== 1'b0) begin fails++; $display("FAIL rmf_single got %b want 0", r_vld); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_invalid_id();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_fixed_mc.md
# acc_fixed_mc

Multi-channel, frame-delimited signed fixed-point accumulator with AXI-Stream input and output, parametrised in sample width, accumulator width, channel count and output buffer depth. Sits between the mel-filterbank/DCT datapath and the CNN feature buffer. It sums interleaved per-channel sample streams, one accumulator per channel, and emits one result per channel frame, closed by `tlast`. It provides per-frame overflow reporting and optional saturation.

## Interface
- `DATA_W`, 32: signed input sample width.
- `ACC_W`, 40: signed accumulator/result width; must satisfy `ACC_W` ≥ `DATA_W`.
- `CH`, 4: number of channels, 1..256.
- `CH_W`, `$clog2(CH)` (min 1): channel id width.
- `OUT_DEPTH`, 4: result FIFO depth, power of two, ≥2.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_a_tvalid`  in  1  input beat valid.
- `s_axis_a_tready`  out  1  input ready.
- `s_axis_a_tdata`  in  DATA_W  signed sample.
- `s_axis_a_tid`  in  CH_W  channel id of the beat.
- `s_axis_a_tlast`  in  1  last beat of this channel's frame.
- `m_axis_result_tvalid`  out  1  result valid.
- `m_axis_result_tready`  in  1  downstream ready.
- `m_axis_result_tdata`  out  ACC_W  signed frame sum.
- `m_axis_result_tid`  out  CH_W  channel of the result.
- `m_axis_result_tuser`  out  1  overflow occurred in this frame.
- `count_dropped`  out  16  saturating count of beats with an out-of-range `tid`.

## Operation
- Beat accepted when `s_axis_a_tvalid && s_axis_a_tready`.
- State per channel: `acc[c]` (ACC_W), sticky `ovf[c]`.
- Accepted beat, `tid < CH`, `tlast=0`:
  - `acc[tid] <= acc[tid] + sext(tdata)`.
  - `ovf[tid]` is set if the signed add overflows ACC_W.
- Accepted beat, `tid < CH`, `tlast=1`:
  - Write `{sum, tid, ovf[tid] | this_ovf}` into the result FIFO, where `sum` is the final add.
  - Clear `acc[tid]` to 0 and `ovf[tid]` to 0 in the same edge.
- Accepted beat with `tid ≥ CH` (only possible when CH is not a power of two):
  - The beat is consumed and discarded. No state changes.
  - `count_dropped` increments and saturates at 0xFFFF.
- Overflow: signed overflow is true when both operands have the same sign and the result sign differs.
- Channels are independent. Frames of different channels may interleave arbitrarily at beat granularity.
- A single-beat frame (`tlast` on the first beat) outputs `sext(tdata)`.
- Result FIFO:
  - `OUT_DEPTH` entries, first-word fall-through.
  - Output fields are driven from the head entry.
  - Pop on `m_axis_result_tvalid && m_axis_result_tready`.

## Timing
- `s_axis_a_tready = !fifo_full`. It does not depend on `m_axis_result_tready`; no combinational in→out path.
- With the FIFO full, a simultaneous pop does not enable the push in that cycle. Ready rises the cycle after the pop.
- Latency: a `tlast` beat accepted at edge N gives `m_axis_result_tvalid=1` from edge N onward, i.e. visible in cycle N+1, provided the FIFO was empty.
- Throughput: one input beat per cycle, including back-to-back beats on the same channel (single-cycle read-modify-write, no hazard).
- Output holds `tdata`/`tid`/`tuser` stable while `tvalid && !tready`.
- Reset values:
  - `s_axis_a_tready=0` while `areset` is high, 1 the first cycle after release.
  - `m_axis_result_tvalid=0`; `m_axis_result_tdata`, `tid`, `tuser` = 0.
  - `count_dropped=0`.
  - All `acc`/`ovf` = 0 and the FIFO is empty.
- Reset mid-frame: partial sums and pending results are discarded. No result is emitted for the interrupted frames.

## Configuration
- `ACC_SAT_EN` defined:
  - On overflow, the stored/emitted sum clamps to `2^(ACC_W-1)-1` (positive) or `-2^(ACC_W-1)` (negative).
  - Later adds continue from the clamped value.
  - `tuser` still reports the overflow.
- `ACC_SAT_EN` undefined:
  - Two's-complement wrap modulo `2^ACC_W`.
  - `tuser` still reports the overflow.

## Test plan
- Basic frame (CH=4, ACC_W=40): ch0 beats 100, 100, 100, 100 with `tlast` on the 4th → one result, tdata=400, tid=0, tuser=0, tvalid in the cycle after the 4th beat.
- Interleave: ch0=5, ch1=-7, ch0=5(last), ch1=-7(last) → results (10, tid 0) then (-14, tid 1), in that order.
- Backpressure (OUT_DEPTH=4): `m_axis_result_tready=0`, five single-beat frames → `s_axis_a_tready` falls after the 4th. Raise `tready` → the 4 results drain in order, ready returns the cycle after the first pop, and the 5th is accepted and emitted.
- Overflow (ACC_W=34, DATA_W=32): five beats of 0x7FFFFFFF on ch2, `tlast` on the 5th.
  - With `ACC_SAT_EN`: tdata=0x1_FFFF_FFFF, tuser=1.
  - Without: tdata=0x2_7FFF_FFFB (wrapped), tuser=1.
  - Next frame 1(last) on ch2 → tdata=1, tuser=0.
- Reset mid-frame: ch3 beats 50, 50, assert `areset` 2 cycles, then 9(last) on ch3 → result 9, tuser=0, and no earlier output.
- Invalid id (CH=3): beat with tid=3, value 77 → no result, `count_dropped`=1, and channel 0–2 sums are unaffected.
